// File: rtl/frame_compare_engine.sv
// frame_compare_engine
// Raster-scans a DUT image bank and a golden image bank in lockstep through a
// 1-cycle-latency read port, counts mismatches per channel (saturating) and
// records the first mismatching pixel in raster order.
// Optional feature macro: FCE_TOL_EN (tolerance compare, |diff| > tol).
module frame_compare_engine #(
  parameter int CH    = 4,
  parameter int PIX_W = 8,
  parameter int ROWS  = 480,
  parameter int COLS  = 640,
  parameter int ROW_W = 9,
  parameter int COL_W = 10,
  parameter int CNT_W = 19,
  parameter int CH_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PIX_W-1:0]    tol,
  output logic                rd_en,
  output logic [ROW_W-1:0]    rd_row,
  output logic [COL_W-1:0]    rd_col,
  input  logic [CH*PIX_W-1:0] dut_data,
  input  logic [CH*PIX_W-1:0] gold_data,
  output logic                busy,
  output logic                done,
  output logic [CH*CNT_W-1:0] err_cnt,
  output logic                first_err_valid,
  output logic [ROW_W-1:0]    first_err_row,
  output logic [COL_W-1:0]    first_err_col,
  output logic [CH_W-1:0]     first_err_ch,
  output logic [PIX_W-1:0]    first_err_dut,
  output logic [PIX_W-1:0]    first_err_gold
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

`ifdef FCE_TOL_EN
  // Tolerance compare: the difference is taken one bit wider than a pixel so
  // both signs fit, and its magnitude is compared against tol.
  function automatic logic pix_mismatch(input logic [PIX_W-1:0] a,
                                        input logic [PIX_W-1:0] b,
                                        input logic [PIX_W-1:0] t);
    logic [PIX_W:0] diff;
    logic [PIX_W:0] mag;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[PIX_W]) begin
      mag = ~diff + {{PIX_W{1'b0}}, 1'b1};
    end else begin
      mag = diff;
    end
    return (mag > {1'b0, t});
  endfunction
`else
  // Exact compare: any nonzero difference is a mismatch.
  function automatic logic pix_mismatch(input logic [PIX_W-1:0] a,
                                        input logic [PIX_W-1:0] b);
    logic [PIX_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return (diff != {(PIX_W+1){1'b0}});
  endfunction

  // tol is a port of every build but only tolerance builds consume it.
  logic tol_unused_s;
  assign tol_unused_s = ^tol;
`endif

  logic [1:0]       state_q, state_d;
  logic             rd_en_q, rd_en_d;
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;
  logic             v_q, v_d;
  logic [ROW_W-1:0] v_row_q, v_row_d;
  logic [COL_W-1:0] v_col_q, v_col_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  logic             fe_valid_q, fe_valid_d;
  logic [ROW_W-1:0] fe_row_q, fe_row_d;
  logic [COL_W-1:0] fe_col_q, fe_col_d;
  logic [CH_W-1:0]  fe_ch_q, fe_ch_d;
  logic [PIX_W-1:0] fe_dut_q, fe_dut_d;
  logic [PIX_W-1:0] fe_gold_q, fe_gold_d;

  logic [CH-1:0]    mism_s;
  logic [CH_W-1:0]  sel_ch_s;
  logic [PIX_W-1:0] sel_dut_s;
  logic [PIX_W-1:0] sel_gold_s;

  // Per-channel mismatch flags for the pixel currently on the data buses.
  always_comb begin
    mism_s = {CH{1'b0}};
    for (int c = 0; c < CH; c++) begin
`ifdef FCE_TOL_EN
      mism_s[c] = pix_mismatch(dut_data[c*PIX_W +: PIX_W],
                               gold_data[c*PIX_W +: PIX_W], tol);
`else
      mism_s[c] = pix_mismatch(dut_data[c*PIX_W +: PIX_W],
                               gold_data[c*PIX_W +: PIX_W]);
`endif
    end
  end

  // Pick the lowest mismatching channel; scanning downward lets it win.
  always_comb begin
    sel_ch_s   = {CH_W{1'b0}};
    sel_dut_s  = {PIX_W{1'b0}};
    sel_gold_s = {PIX_W{1'b0}};
    for (int c = CH - 1; c >= 0; c--) begin
      if (mism_s[c]) begin
        sel_ch_s   = CH_W'(c);
        sel_dut_s  = dut_data[c*PIX_W +: PIX_W];
        sel_gold_s = gold_data[c*PIX_W +: PIX_W];
      end else begin
        sel_ch_s = sel_ch_s;
      end
    end
  end

  // Next-state logic: scan sequencer, compare pipeline and result capture.
  always_comb begin
    state_d    = state_q;
    rd_en_d    = rd_en_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;
    fe_valid_d = fe_valid_q;
    fe_row_d   = fe_row_q;
    fe_col_d   = fe_col_q;
    fe_ch_d    = fe_ch_q;
    fe_dut_d   = fe_dut_q;
    fe_gold_d  = fe_gold_q;
    for (int c = 0; c < CH; c++) begin
      cnt_d[c] = cnt_q[c];
    end

    // The delayed strobe/address tag the data returning this cycle.
    v_d     = rd_en_q;
    v_row_d = rd_row_q;
    v_col_d = rd_col_q;

    if (v_q) begin
      for (int c = 0; c < CH; c++) begin
        if (mism_s[c] && (cnt_q[c] != CNT_MAX)) begin
          cnt_d[c] = cnt_q[c] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d[c] = cnt_q[c];
        end
      end
      if (!fe_valid_q && (|mism_s)) begin
        fe_valid_d = 1'b1;
        fe_row_d   = v_row_q;
        fe_col_d   = v_col_q;
        fe_ch_d    = sel_ch_s;
        fe_dut_d   = sel_dut_s;
        fe_gold_d  = sel_gold_s;
      end else begin
        fe_valid_d = fe_valid_q;
      end
    end else begin
      fe_valid_d = fe_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SCAN;
          rd_en_d    = 1'b1;
          rd_row_d   = {ROW_W{1'b0}};
          rd_col_d   = {COL_W{1'b0}};
          fe_valid_d = 1'b0;
          fe_row_d   = {ROW_W{1'b0}};
          fe_col_d   = {COL_W{1'b0}};
          fe_ch_d    = {CH_W{1'b0}};
          fe_dut_d   = {PIX_W{1'b0}};
          fe_gold_d  = {PIX_W{1'b0}};
          for (int c = 0; c < CH; c++) begin
            cnt_d[c] = {CNT_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (rd_col_q == LAST_COL) begin
          rd_col_d = {COL_W{1'b0}};
          if (rd_row_q == LAST_ROW) begin
            state_d  = S_DRAIN;
            rd_en_d  = 1'b0;
            rd_row_d = {ROW_W{1'b0}};
          end else begin
            rd_row_d = rd_row_q + {{(ROW_W-1){1'b0}}, 1'b1};
          end
        end else begin
          rd_col_d = rd_col_q + {{(COL_W-1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rd_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_SCAN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset abandons any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_en_q    <= 1'b0;
      rd_row_q   <= {ROW_W{1'b0}};
      rd_col_q   <= {COL_W{1'b0}};
      v_q        <= 1'b0;
      v_row_q    <= {ROW_W{1'b0}};
      v_col_q    <= {COL_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_row_q   <= {ROW_W{1'b0}};
      fe_col_q   <= {COL_W{1'b0}};
      fe_ch_q    <= {CH_W{1'b0}};
      fe_dut_q   <= {PIX_W{1'b0}};
      fe_gold_q  <= {PIX_W{1'b0}};
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= {CNT_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      v_q        <= v_d;
      v_row_q    <= v_row_d;
      v_col_q    <= v_col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fe_valid_q <= fe_valid_d;
      fe_row_q   <= fe_row_d;
      fe_col_q   <= fe_col_d;
      fe_ch_q    <= fe_ch_d;
      fe_dut_q   <= fe_dut_d;
      fe_gold_q  <= fe_gold_d;
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Flatten the per-channel counters onto the packed output bus.
  always_comb begin
    err_cnt = {(CH*CNT_W){1'b0}};
    for (int c = 0; c < CH; c++) begin
      err_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end

  assign rd_en           = rd_en_q;
  assign rd_row          = rd_row_q;
  assign rd_col          = rd_col_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_row   = fe_row_q;
  assign first_err_col   = fe_col_q;
  assign first_err_ch    = fe_ch_q;
  assign first_err_dut   = fe_dut_q;
  assign first_err_gold  = fe_gold_q;

endmodule

// File: tb/tb_frame_compare_engine.sv
// Scoreboard bench for frame_compare_engine on a 4x5 frame, 4 channels,
// 3-bit counters (so a full-frame channel mismatch saturates at 7).
module tb_frame_compare_engine;
  localparam int CH = 4, PIX_W = 8, ROWS = 4, COLS = 5;
  localparam int ROW_W = 3, COL_W = 3, CNT_W = 3, CH_W = 2;

  typedef struct packed {
    logic [CH*CNT_W-1:0] cnt;
    logic                fv;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [CH_W-1:0]     ch;
    logic [PIX_W-1:0]    dv;
    logic [PIX_W-1:0]    gv;
  } exp_t;

  logic clk, rst_n, start;
  logic [PIX_W-1:0] tol;
  logic rd_en, busy, done, first_err_valid;
  logic [ROW_W-1:0] rd_row, first_err_row;
  logic [COL_W-1:0] rd_col, first_err_col;
  logic [CH*PIX_W-1:0] dut_data, gold_data;
  logic [CH*CNT_W-1:0] err_cnt;
  logic [CH_W-1:0] first_err_ch;
  logic [PIX_W-1:0] first_err_dut, first_err_gold;

  logic [PIX_W-1:0] dmem [ROWS][COLS][CH];
  logic [PIX_W-1:0] gmem [ROWS][COLS][CH];

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int rd_cnt = 0, busy_cnt = 0, done_seen = 0;
  logic prev_busy = 1'b0;

  frame_compare_engine #(.CH(CH), .PIX_W(PIX_W), .ROWS(ROWS), .COLS(COLS),
    .ROW_W(ROW_W), .COL_W(COL_W), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tol(tol),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .dut_data(dut_data), .gold_data(gold_data),
    .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_row(first_err_row),
    .first_err_col(first_err_col), .first_err_ch(first_err_ch),
    .first_err_dut(first_err_dut), .first_err_gold(first_err_gold));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data for an address strobed in cycle k is valid in k+1;
  // otherwise the buses carry deliberately unequal junk.
  always @(posedge clk) begin
    if (rd_en) begin
      for (int c = 0; c < CH; c++) begin
        dut_data[c*PIX_W +: PIX_W]  <= dmem[rd_row][rd_col][c];
        gold_data[c*PIX_W +: PIX_W] <= gmem[rd_row][rd_col][c];
      end
    end else begin
      dut_data  <= {CH{8'hAA}};
      gold_data <= {CH{8'h55}};
    end
  end

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Monitor: on each done pulse pop the expected result and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0; busy_cnt = 0; prev_busy = 1'b0;
    end else begin
      if (rd_en) rd_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          for (int c = 0; c < CH; c++)
            chk($sformatf("err_cnt%0d", c), err_cnt[c*CNT_W +: CNT_W], e.cnt[c*CNT_W +: CNT_W]);
          chk("first_err_valid", first_err_valid, e.fv);
          chk("first_err_row", first_err_row, e.row);
          chk("first_err_col", first_err_col, e.col);
          chk("first_err_ch", first_err_ch, e.ch);
          chk("first_err_dut", first_err_dut, e.dv);
          chk("first_err_gold", first_err_gold, e.gv);
          chk("rd_en_cycles", rd_cnt, ROWS*COLS);
          chk("busy_cycles", busy_cnt, ROWS*COLS + 1);
          chk("done_after_busy", prev_busy, 1);
        end
        rd_cnt = 0; busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  function automatic exp_t mk(int c0, int c1, int c2, int c3, int fv,
                              int r, int cl, int ch, int dv, int gv);
    exp_t e;
    e.cnt = {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
    e.fv = fv[0]; e.row = ROW_W'(r); e.col = COL_W'(cl);
    e.ch = CH_W'(ch); e.dv = PIX_W'(dv); e.gv = PIX_W'(gv);
    return e;
  endfunction

  task automatic init_banks();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int h = 0; h < CH; h++) begin
          gmem[r][c][h] = PIX_W'(r*16 + c*3 + h*40);
          dmem[r][c][h] = PIX_W'(r*16 + c*3 + h*40);
        end
  endtask

  // Issue one scan; optionally pulse start again while busy (poke>0).
  task automatic run_scan(input exp_t e, input int poke);
    int got;
    exp_q.push_back(e);
    got = done_seen;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_seen != got) break;
      start = (i == poke) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_seen == got) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tol = 8'd0;
    dut_data = '0; gold_data = '0;
    init_banks();
    repeat (3) @(negedge clk);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_fev", first_err_valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identical banks.
    run_scan(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1);

    // ch2 at (1,3) 100 vs 97, ch1 at (2,0) off by one.
    init_banks();
    dmem[1][3][2] = 8'd100; gmem[1][3][2] = 8'd97;
    dmem[2][0][1] = 8'd73;  // gold is 72
    run_scan(mk(0, 1, 1, 0, 1, 1, 3, 2, 100, 97), -1);

    // Clean scan with a start pulse while busy: counters restart from 0.
    init_banks();
    run_scan(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5);

    // ch0 and ch3 at (0,0), ch3 at last pixel (3,4).
    init_banks();
    dmem[0][0][0] = 8'd9;    // gold 0
    dmem[0][0][3] = 8'd121;  // gold 120
    dmem[3][4][3] = 8'd185;  // gold 180
    run_scan(mk(1, 0, 0, 2, 1, 0, 0, 0, 9, 0), -1);

    // Diffs +2,-2,+3,-3 on ch0 with tol=2, then tol=0.
    init_banks();
    for (int r = 0; r < ROWS; r++) gmem[r][1][0] = 8'd50;
    dmem[0][1][0] = 8'd52; dmem[1][1][0] = 8'd48;
    dmem[2][1][0] = 8'd53; dmem[3][1][0] = 8'd47;
    tol = 8'd2;
`ifdef FCE_TOL_EN
    run_scan(mk(2, 0, 0, 0, 1, 2, 1, 0, 53, 50), -1);
`else
    run_scan(mk(4, 0, 0, 0, 1, 0, 1, 0, 52, 50), -1);
`endif
    tol = 8'd0;
    run_scan(mk(4, 0, 0, 0, 1, 0, 1, 0, 52, 50), -1);

    // Every ch0 pixel differs: counter saturates at 7.
    init_banks();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) dmem[r][c][0] = gmem[r][c][0] ^ 8'd1;
    run_scan(mk(7, 0, 0, 0, 1, 0, 0, 0, 1, 0), -1);

    // Reset mid-scan: outputs clear, no done pulse follows.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_rd_addr", {rd_row, rd_col}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err_cnt", err_cnt, 0);
    chk("abort_fev", first_err_valid, 0);
    chk("abort_fe_fields", {first_err_row, first_err_col, first_err_ch,
                            first_err_dut, first_err_gold}, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_seen, 7);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_compare_engine.md
# frame_compare_engine

Synthesizable multi-channel frame comparator that raster-scans a DUT image memory bank and a golden image memory bank in lockstep and reports per-channel mismatch counts plus the first mismatching pixel. It sits beside `CORE` on the verification/BIST path. It generalises the 4-way 640x480 blur-image check into hardware, parametrised in channel count, pixel width and frame size, with an optional tolerance mode. It reads the `blur_img_*` memories, or any same-shaped bank, through a 1-cycle-latency read port.

## Interface

- CH, 4, channels compared in parallel
- PIX_W, 8, pixel width in bits
- ROWS, 480, frame rows
- COLS, 640, frame columns
- ROW_W, 9, row address width (2^ROW_W >= ROWS)
- COL_W, 10, column address width (2^COL_W >= COLS)
- CNT_W, 19, error counter width (2^CNT_W > ROWS*COLS)
- CH_W, 2, channel index width (2^CH_W >= CH)

Ports:

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin scan; sampled only in IDLE
- tol  in  PIX_W  allowed absolute difference; used only with FCE_TOL_EN
- rd_en  out  1  read strobe to both memory banks
- rd_row  out  ROW_W  read row address
- rd_col  out  COL_W  read column address
- dut_data  in  CH*PIX_W  DUT pixels; channel c at [c*PIX_W+:PIX_W]; valid 1 cycle after rd_en
- gold_data  in  CH*PIX_W  golden pixels, same packing and latency
- busy  out  1  high in SCAN and DRAIN
- done  out  1  one-cycle pulse when results are final
- err_cnt  out  CH*CNT_W  per-channel mismatch counts, channel c at [c*CNT_W+:CNT_W]
- first_err_valid  out  1  at least one mismatch seen in this scan
- first_err_row / first_err_col  out  ROW_W / COL_W  location of first mismatch
- first_err_ch  out  CH_W  channel of first mismatch
- first_err_dut / first_err_gold  out  PIX_W  the two values at first mismatch

## Operation

- FSM states: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE -> SCAN:
  - Occurs when start=1 at a rising edge.
  - The same edge clears err_cnt, first_err_* and first_err_valid, and sets the address to (0,0).
- SCAN:
  - rd_en=1 every cycle.
  - Address advances in raster order: col increments; at col COLS-1 it wraps to 0 and row increments.
  - After (ROWS-1, COLS-1) is issued, the FSM goes to DRAIN.
- DRAIN: rd_en=0. The last pixel's data is compared.
- DONE: done=1 for one cycle, then IDLE.
- Compare pipeline:
  - A 1-cycle delayed copy of rd_en/row/col qualifies the returning data.
  - Counters and first-error fields update at the edge ending the data-valid cycle.
- Mismatch per channel:
  - diff = {1'b0,dut} - {1'b0,gold}, PIX_W+1 bits signed.
  - Without FCE_TOL_EN: mismatch when diff != 0.
- err_cnt[c] increments by 1 per mismatch and saturates at 2^CNT_W-1.
- First error:
  - Captured once per scan, at the earliest mismatching pixel in raster order.
  - If several channels mismatch at that pixel, the lowest channel index wins.
  - first_err_valid is set at the same time.
- Outputs hold their values from DONE until the next accepted start.
- start is ignored while busy or in DONE.
- rst_n low at any time, including mid-scan: immediately IDLE; all outputs 0; the in-flight scan is discarded.

## Timing

- Reset values: rd_en, rd_row, rd_col, busy, done, err_cnt, all first_err_* = 0.
- With N = ROWS*COLS and start sampled at edge E0:
  - rd_en is high for cycles 1..N after E0.
  - DRAIN is cycle N+1.
  - done is high in cycle N+2.
- Total start-to-done latency: N+2 cycles. Default config: 307202 cycles.
- Throughput: 1 pixel per channel per cycle; no stalls.
- Memory contract: the data for the address presented with rd_en in cycle k is valid throughout cycle k+1.

## Configuration

- FCE_TOL_EN defined:
  - Mismatch when |diff| > tol. tol=0 is equivalent to exact compare.
  - |diff| is computed in PIX_W+1 bits.
  - tol must be held stable during busy.
- FCE_TOL_EN undefined: exact compare; the tol port exists but is unused.

## Test plan

- Use ROWS=4, COLS=5, CH=4, PIX_W=8 unless stated.
- Identical banks, start pulse -> done at cycle 22 after start edge; rd_en high exactly 20 cycles; all err_cnt=0; first_err_valid=0.
- DUT ch2 at (1,3) = 100, gold = 97; ch1 at (2,0) mismatched -> err_cnt = {0,1,1,0}; first_err = row 1, col 3, ch 2, dut 100, gold 97.
- Ch0 and ch3 both mismatch at (0,0), plus ch3 at (3,4) -> first_err_ch=0; err_cnt[3]=2; last-pixel mismatch is counted before done.
- FCE_TOL_EN, tol=2, diffs of +2, -2, +3, -3 on ch0 -> err_cnt[0]=2. Repeat with tol=0 -> 4. Repeat without the macro -> 4.
- CNT_W=3, all 20 pixels of ch0 differ -> err_cnt[0] saturates at 7.
- rst_n low at cycle 10 of a scan -> all outputs 0 next cycle, no done pulse. Start pulses during busy -> ignored; next start after done -> counters restart from 0.
